fir_ctrl: RTL and testbench

//  Sample-rate controller directly upstream of the adaptive FIR. Buffers ADC sample triples
//  (reference x, error e, primary a) and forms the LMS step mu*e. Issues one fir_go per

---
 rtl/fir_ctrl_pkg.sv | 29 ++
 rtl/fir_ctrl_sample_fifo.sv | 57 +++++
 rtl/fir_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fir_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_ctrl_pkg
//  Purpose  : Shared types and constants for the FIR sample-rate controller.
//  Revision : 1.0  initial release
// ============================================================================
package fir_ctrl_pkg;

  localparam int SMP_W  = 16;
  localparam int PROD_W = 32;

  localparam logic [SMP_W-1:0] Q15_MAX = 16'h7FFF;
  localparam logic [SMP_W-1:0] Q15_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_GO   = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  typedef struct packed {
    logic [SMP_W-1:0] x;
    logic [SMP_W-1:0] e;
    logic [SMP_W-1:0] a;
  } triple_t;

endpackage
`default_nettype wire

// File: rtl/fir_ctrl_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fir_ctrl_sample_fifo
//  Purpose  : DEPTH x 48b synchronous FIFO of sample triples, full/empty flags.
//             A push on a full FIFO is accepted only with a same-cycle pop.
//  Revision : 1.0  initial release
// ============================================================================
module fir_ctrl_sample_fifo
  import fir_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  logic    pop,
  input  triple_t din,
  output triple_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  triple_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            wr_en;
  logic            rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  // Storage array; contents are don't-care after reset since pointers restart.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fir_ctrl
//  Purpose  : Sample-rate controller ahead of the adaptive FIR. Buffers sample
//             triples, forms sat(mu*e), launches one FIR run per sample and
//             forwards the FIR result to the speaker path.
//  Options  : FIR_CTRL_STATS_EN - enables the stat_runs/stat_drops counters.
//  Revision : 1.0  initial release
// ============================================================================
module fir_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int TAPS       = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = TAPS + 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_en,
  input  logic             smp_valid,
  input  logic [SMP_W-1:0] smp_x,
  input  logic [SMP_W-1:0] smp_e,
  input  logic [SMP_W-1:0] smp_a,
  input  logic [SMP_W-1:0] mu,
  input  logic             adapt_en,
  output logic [SMP_W-1:0] x_in,
  output logic [SMP_W-1:0] a_in,
  output logic [SMP_W-1:0] weight_adjust,
  output logic             fir_go,
  input  logic             fir_done,
  input  logic [SMP_W-1:0] fir_out,
  output logic [SMP_W-1:0] spk_sample,
  output logic             spk_valid,
  output logic             err_ovf,
  output logic             err_tmo,
  input  logic             err_clr,
  output logic [SMP_W-1:0] stat_runs,
  output logic [SMP_W-1:0] stat_drops
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state, state_nxt;
  logic                pop;
  logic                fifo_full, fifo_empty;
  triple_t             head, cur;
  logic [SMP_W-1:0]    mu_r;
  logic [TW-1:0]       tmo_cnt;
  logic                tmo_hit, done_evt, tmo_evt, drop_evt;
  logic [PROD_W-1:0]   prod;
  logic [SMP_W-1:0]    wadj_sat;
  logic                unused_prod_bits;

  fir_ctrl_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (smp_valid),
    .pop   (pop),
    .din   ('{x: smp_x, e: smp_e, a: smp_a}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign drop_evt = smp_valid && fifo_full && !pop;
  assign tmo_hit  = (state == ST_WAIT) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign done_evt = (state == ST_WAIT) && fir_done;
  assign tmo_evt  = tmo_hit && !fir_done;
  assign fir_go   = (state == ST_GO);

  // Full-precision signed product; the only Q1.15 overflow is (-1)*(-1).
  assign prod     = $signed({{SMP_W{mu_r[SMP_W-1]}}, mu_r}) *
                    $signed({{SMP_W{cur.e[SMP_W-1]}}, cur.e});
  assign wadj_sat = (mu_r == Q15_MIN && cur.e == Q15_MIN) ? Q15_MAX : prod[30:15];
  assign unused_prod_bits = ^{prod[PROD_W-1], prod[14:0]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and pop decode; done takes priority over timeout.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !scan_en) begin
          pop       = 1'b1;
          state_nxt = ST_MUL;
        end
      end
      ST_MUL:  state_nxt = ST_GO;
      ST_GO:   state_nxt = ST_WAIT;
      ST_WAIT: if (fir_done || tmo_hit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture at pop, form FIR operands in MUL, time the wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur           <= '0;
      mu_r          <= '0;
      x_in          <= '0;
      a_in          <= '0;
      weight_adjust <= '0;
      tmo_cnt       <= '0;
      spk_sample    <= '0;
      spk_valid     <= 1'b0;
    end else begin
      if (pop) begin
        cur  <= head;
        mu_r <= mu;
      end
      if (state == ST_MUL) begin
        x_in          <= cur.x;
        a_in          <= cur.a;
        weight_adjust <= adapt_en ? wadj_sat : '0;
      end
      if (state == ST_GO)        tmo_cnt <= '0;
      else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      spk_valid <= done_evt;
      if (done_evt) spk_sample <= fir_out;
    end
  end

  // Sticky error flags; a same-cycle error event overrides the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      err_ovf <= drop_evt | (err_ovf & ~err_clr);
      err_tmo <= tmo_evt  | (err_tmo & ~err_clr);
    end
  end

`ifdef FIR_CTRL_STATS_EN
  logic [SMP_W-1:0] runs_q, drops_q;

  // Wrapping statistics counters, restarted by err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runs_q  <= '0;
      drops_q <= '0;
    end else if (err_clr) begin
      runs_q  <= {{(SMP_W-1){1'b0}}, done_evt};
      drops_q <= {{(SMP_W-1){1'b0}}, drop_evt};
    end else begin
      if (done_evt) runs_q  <= runs_q + 1'b1;
      if (drop_evt) drops_q <= drops_q + 1'b1;
    end
  end

  assign stat_runs  = runs_q;
  assign stat_drops = drops_q;
`else
  assign stat_runs  = '0;
  assign stat_drops = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_ctrl
//  Purpose  : Self-checking bench for fir_ctrl: transaction-level reference
//             model compared every cycle, plus directed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_ctrl;

  localparam int TB_TAPS    = 16;
  localparam int TB_TIMEOUT = TB_TAPS + 16;
  localparam int TB_DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst_n, scan_en, smp_valid, adapt_en, fir_done, err_clr;
  logic [15:0] smp_x, smp_e, smp_a, mu, fir_out;
  logic [15:0] x_in, a_in, weight_adjust, spk_sample, stat_runs, stat_drops;
  logic        fir_go, spk_valid, err_ovf, err_tmo;

  int errors = 0;
  int checks = 0;

  fir_ctrl #(.TAPS(TB_TAPS), .FIFO_DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .smp_valid(smp_valid),
    .smp_x(smp_x), .smp_e(smp_e), .smp_a(smp_a), .mu(mu), .adapt_en(adapt_en),
    .x_in(x_in), .a_in(a_in), .weight_adjust(weight_adjust), .fir_go(fir_go),
    .fir_done(fir_done), .fir_out(fir_out), .spk_sample(spk_sample),
    .spk_valid(spk_valid), .err_ovf(err_ovf), .err_tmo(err_tmo),
    .err_clr(err_clr), .stat_runs(stat_runs), .stat_drops(stat_drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct { logic [15:0] x, e, a; } trip_t;
  trip_t       mq[$];
  trip_t       cur;
  logic [15:0] cmu;
  bit          busy;
  int          age;            // cycles since the sample was taken from the buffer
  logic [15:0] ex, ea, ew, espk;
  bit          esv, eovf, etmo;
  logic [15:0] eruns, edrops;

  function automatic logic [15:0] exp_w(input logic [15:0] m, input logic [15:0] e);
    int p;
    p = int'($signed(m)) * int'($signed(e));
    p = p >>> 15;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit m_pop, in_wait, done_now, tmo_now, drop;
    if (!rst_n) begin
      mq.delete(); busy = 0; age = 0; cmu = 0;
      ex = 0; ea = 0; ew = 0; espk = 0; esv = 0; eovf = 0; etmo = 0;
      eruns = 0; edrops = 0;
    end else begin
      m_pop    = !busy && mq.size() > 0 && !scan_en;
      in_wait  = busy && age >= 3;
      done_now = in_wait && fir_done;
      tmo_now  = in_wait && !fir_done && (age - 3 == TB_TIMEOUT - 1);
      drop     = smp_valid && mq.size() == TB_DEPTH && !m_pop;
      esv = done_now;
      if (done_now) espk = fir_out;
      if (busy && age == 1) begin
        ex = cur.x; ea = cur.a;
        ew = adapt_en ? exp_w(cmu, cur.e) : 16'h0;
      end
      if (m_pop) begin cur = mq.pop_front(); cmu = mu; end
      if (smp_valid && !drop) mq.push_back('{smp_x, smp_e, smp_a});
      eovf = drop    || (eovf && !err_clr);
      etmo = tmo_now || (etmo && !err_clr);
      if (err_clr) begin eruns = 0; edrops = 0; end
      if (done_now) eruns++;
      if (drop) edrops++;
      if (m_pop) begin busy = 1; age = 1; end
      else if (busy) begin
        if (done_now || tmo_now) busy = 0; else age++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("go",    {15'h0, fir_go},    {15'h0, busy && age == 2});
    chk("x_in",  x_in,  ex);
    chk("a_in",  a_in,  ea);
    chk("wadj",  weight_adjust, ew);
    chk("spk",   spk_sample, espk);
    chk("spk_v", {15'h0, spk_valid}, {15'h0, esv});
    chk("ovf",   {15'h0, err_ovf},   {15'h0, eovf});
    chk("tmo",   {15'h0, err_tmo},   {15'h0, etmo});
`ifdef FIR_CTRL_STATS_EN
    chk("runs",  stat_runs,  eruns);
    chk("drops", stat_drops, edrops);
`else
    chk("runs",  stat_runs,  16'h0);
    chk("drops", stat_drops, 16'h0);
`endif
  end

  // ---------------- FIR responder ----------------
  int          fir_lat = 2;
  bit          fir_never = 0;
  bit          stray = 0;
  logic [15:0] fir_val = 16'h0;
  int          cd = 0;

  initial begin
    fir_done = 0; fir_out = 0;
    forever begin
      @(posedge clk); #1;
      fir_done = 0;
      if (stray) begin
        fir_done = 1; fir_out = 16'h1111; stray = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin fir_done = 1; fir_out = fir_val; end
      end
      if (fir_go && !fir_never) cd = fir_lat;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] e, input logic [15:0] a);
    smp_valid = 1; smp_x = x; smp_e = e; smp_a = a;
    tick();
    smp_valid = 0;
  endtask

  task automatic wait_go(output int n, input int lim);
    n = 1;
    while (!fir_go && n < lim) begin tick(); n++; end
    if (!fir_go) chk("go_timeout", 16'h0, 16'h1);
  endtask

  task automatic wait_spk(input int lim);
    int n = 0;
    while (!spk_valid && n < lim) begin tick(); n++; end
    if (!spk_valid) chk("spk_timeout", 16'h0, 16'h1);
  endtask

  initial begin
    int n, seen;
    rst_n = 0; scan_en = 0; smp_valid = 0; adapt_en = 1; err_clr = 0;
    smp_x = 0; smp_e = 0; smp_a = 0; mu = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go", {15'h0, fir_go}, 16'h0);
    chk("rst_x", x_in, 16'h0);
    chk("rst_spk", spk_sample, 16'h0);
    chk("rst_ovf", {15'h0, err_ovf}, 16'h0);
    rst_n = 1;
    tick();

    // Basic run: latency and operand values.
    fir_lat = 2; fir_val = 16'h1234; mu = 16'h4000;
    send(16'h1000, 16'h4000, 16'h0100);
    wait_go(n, 10);
    chk("t1_lat", 16'(n), 16'd3);
    chk("t1_x", x_in, 16'h1000);
    chk("t1_a", a_in, 16'h0100);
    chk("t1_w", weight_adjust, 16'h2000);
    wait_spk(50);
    chk("t1_spk", spk_sample, 16'h1234);

    // Saturation corner, then the same with adaptation frozen.
    mu = 16'h8000;
    send(16'h0000, 16'h8000, 16'h0000);
    wait_go(n, 10);
    chk("sat_w", weight_adjust, 16'h7FFF);
    wait_spk(50);
    adapt_en = 0;
    send(16'h0000, 16'h8000, 16'h0000);
    wait_go(n, 10);
    chk("frz_w", weight_adjust, 16'h0000);
    wait_spk(50);
    adapt_en = 1;

    // Negative product and output forwarding with pulse width.
    fir_val = 16'hABCD; mu = 16'hC000;
    send(16'h0200, 16'h2000, 16'h0300);
    wait_go(n, 10);
    chk("neg_w", weight_adjust, 16'hF000);
    wait_spk(50);
    chk("abcd_spk", spk_sample, 16'hABCD);
    tick();
    chk("spk_pulse_w", {15'h0, spk_valid}, 16'h0);

    // Stray done while idle is ignored.
    stray = 1;
    repeat (4) tick();
    chk("stray_spk", spk_sample, 16'hABCD);

    // Overflow: five strobes while the FIR is busy.
    err_clr = 1; tick(); err_clr = 0;
    fir_lat = 30; fir_val = 16'h5555; mu = 16'h4000;
    send(16'h0001, 16'h0001, 16'h0001);
    seen = 0;
    tick(); tick();
    for (int i = 0; i < 5; i++) send(16'(i + 16), 16'(i * 256), 16'(i + 32));
    chk("ovf_set", {15'h0, err_ovf}, 16'h1);
    n = 0;
    while (seen < 5 && n < 400) begin
      if (spk_valid) seen++;
      tick(); n++;
    end
    chk("ovf_runs", 16'(seen), 16'd5);
`ifdef FIR_CTRL_STATS_EN
    chk("stat_drops", stat_drops, 16'd1);
    chk("stat_runs", stat_runs, 16'd5);
`else
    chk("stat_drops", stat_drops, 16'd0);
    chk("stat_runs", stat_runs, 16'd0);
`endif
    err_clr = 1; tick(); err_clr = 0;
    chk("ovf_clr", {15'h0, err_ovf}, 16'h0);

    // Timeout: FIR never answers, then recovers.
    fir_never = 1;
    send(16'h0011, 16'h0022, 16'h0033);
    wait_go(n, 10);
    n = 0;
    while (!err_tmo && n < 100) begin tick(); n++; end
    chk("tmo_cycles", 16'(n), 16'(TB_TIMEOUT + 1));
    fir_never = 0; fir_lat = 3; fir_val = 16'h0F0F;
    send(16'h0044, 16'h0055, 16'h0066);
    wait_spk(50);
    chk("tmo_recover", spk_sample, 16'h0F0F);

    // Scan mode holds off launch.
    scan_en = 1;
    send(16'h0777, 16'h0100, 16'h0888);
    for (int i = 0; i < 10; i++) begin
      chk("scan_nogo", {15'h0, fir_go}, 16'h0);
      tick();
    end
    scan_en = 0;
    n = 0;
    while (!fir_go && n < 10) begin tick(); n++; end
    chk("scan_rel_lat", 16'(n), 16'd2);
    wait_spk(50);

    // Async reset in the middle of a run.
    fir_lat = 20;
    send(16'h0999, 16'h0100, 16'h0AAA);
    tick(); tick();
    #2 rst_n = 0;
    #1;
    chk("arst_x", x_in, 16'h0);
    chk("arst_w", weight_adjust, 16'h0);
    chk("arst_spk", spk_sample, 16'h0);
    chk("arst_tmo", {15'h0, err_tmo}, 16'h0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("arst_nogo", {15'h0, fir_go}, 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
